// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one byte-wide synchronous RAM between 6-byte fetches and 4-byte data accesses.
// Optional MEM_ARB_RR_EN: round-robin tie-break between fetch and data instead of fixed data priority.
module mem_arbiter #(
   parameter int unsigned IF_BYTES = 6,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_ack,
   output logic [8*IF_BYTES-1:0] if_inst,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [31:0]           dm_wdata,
   output logic                  dm_ack,
   output logic [31:0]           dm_rdata,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_wdata,
   input  logic [7:0]            ram_rdata,
   output logic                  busy
);

   localparam int unsigned DM_BYTES = 4;
   localparam int unsigned MAX_B    = (IF_BYTES > DM_BYTES) ? IF_BYTES : DM_BYTES;
   localparam int unsigned CNT_W    = $clog2(MAX_B + 1);
   localparam int unsigned INST_W   = 8 * IF_BYTES;

   typedef enum logic [2:0] {IDLE, IF_RD, DM_RD, DM_WR, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;
   logic [INST_W-1:0]   if_inst_q, if_inst_d;
   logic [31:0]         dm_rdata_q, dm_rdata_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic                ram_we_q, ram_we_d;
   logic [7:0]          ram_wdata_q, ram_wdata_d;
   logic                busy_q, busy_d;
   logic                grant_dm;
   logic [ADDR_W-1:0]   next_addr;

`ifdef MEM_ARB_RR_EN
   logic last_dm_q, last_dm_d;

   // Tie goes to whoever was not served last; a lone requester always wins.
   always_comb begin
      grant_dm  = dm_req && !(if_req && last_dm_q);
      last_dm_d = last_dm_q;
      if (state_q == IDLE && (dm_req || if_req))
         last_dm_d = grant_dm;
   end

   always_ff @(posedge clk) begin
      if (rst) last_dm_q <= 1'b0;
      else     last_dm_q <= last_dm_d;
   end
`else
   always_comb grant_dm = dm_req;
`endif

   // Address presented in the following cycle, wrapping modulo 2^ADDR_W.
   assign next_addr = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_inst_d   = if_inst_q;
      dm_rdata_d  = dm_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;

      case (state_q)
         IDLE: begin
            if (grant_dm) begin
               addr_d     = dm_addr;
               wdata_d    = dm_wdata;
               cnt_d      = '0;
               ram_addr_d = dm_addr;
               if (dm_we) begin
                  state_d     = DM_WR;
                  ram_we_d    = 1'b1;
                  ram_wdata_d = dm_wdata[7:0];
               end else begin
                  state_d = DM_RD;
               end
            end else if (if_req) begin
               addr_d     = if_addr;
               cnt_d      = '0;
               ram_addr_d = if_addr;
               state_d    = IF_RD;
            end
         end
         // RAM data lags the address by one cycle, so byte cnt-1 arrives at cnt.
         IF_RD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q != '0)
               if_inst_d = {if_inst_q[INST_W-9:0], ram_rdata};
            if (cnt_q < CNT_W'(IF_BYTES - 1))
               ram_addr_d = next_addr;
            if (cnt_q == CNT_W'(IF_BYTES)) begin
               state_d  = DONE;
               if_ack_d = 1'b1;
            end
         end
         DM_RD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q != '0)
               dm_rdata_d = {ram_rdata, dm_rdata_q[31:8]};
            if (cnt_q < CNT_W'(DM_BYTES - 1))
               ram_addr_d = next_addr;
            if (cnt_q == CNT_W'(DM_BYTES)) begin
               state_d  = DONE;
               dm_ack_d = 1'b1;
            end
         end
         // Write data shifts down one byte per beat; the low byte went out at grant.
         DM_WR: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DM_BYTES - 1)) begin
               state_d  = DONE;
               dm_ack_d = 1'b1;
            end else begin
               ram_we_d    = 1'b1;
               ram_addr_d  = next_addr;
               ram_wdata_d = wdata_q[15:8];
               wdata_d     = {8'h00, wdata_q[31:8]};
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_inst_q   <= '0;
         dm_rdata_q  <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_inst_q   <= if_inst_d;
         dm_rdata_q  <= dm_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_inst   = if_inst_q;
   assign dm_rdata  = dm_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: vector table of single transactions plus corner-case sequences.
module tb_mem_arbiter;

   logic        clk, rst;
   logic        if_req, if_ack;
   logic [31:0] if_addr;
   logic [47:0] if_inst;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [31:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        busy;

   logic        pl_en;
   logic [7:0]  pl_addr, pl_data;
   logic [7:0]  mem [256];

   int passed = 0;
   int total  = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wide synchronous RAM (low 8 address bits), with a bench preload port.
   always @(posedge clk) begin
      if (pl_en)       mem[pl_addr] <= pl_data;
      else if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[7:0]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic pl(input logic [7:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      step();
      pl_en = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 50) begin step(); g++; end
   endtask

   // One request from IDLE; latency counted from the grant-sampling cycle.
   task automatic do_txn(input bit fetch, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [47:0] data,
                         output int we_cnt, output bit addr_ok, output bit other,
                         output bit pulse_ok);
      int  nb;
      bit  done;
      nb = fetch ? 6 : 4;
      lat = 0; we_cnt = 0; addr_ok = 1'b1; other = 1'b0; done = 1'b0; data = '0;
      wait_idle();
      if (fetch) begin if_addr = addr; if_req = 1'b1; end
      else begin dm_addr = addr; dm_we = we; dm_wdata = wdata; dm_req = 1'b1; end
      while (!done && lat < 30) begin
         step();
         lat++;
         if (ram_we) we_cnt++;
         if (lat <= nb && ram_addr !== addr + 32'(lat - 1)) addr_ok = 1'b0;
         if (fetch ? dm_ack : if_ack) other = 1'b1;
         done = fetch ? if_ack : dm_ack;
      end
      data = fetch ? if_inst : {16'h0, dm_rdata};
      if_req = 1'b0; dm_req = 1'b0;
      step();
      pulse_ok = !(if_ack || dm_ack);
   endtask

   typedef struct {
      bit          fetch;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [47:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int          lat, we_cnt, g;
      logic [47:0] data;
      bit          addr_ok, other, pulse_ok;
      int          order[4];
      int          exp_order[3];

      rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      step(); step();
      pl(8'h10, 8'h30); pl(8'h11, 8'hF0); pl(8'h12, 8'h04);
      pl(8'h13, 8'h00); pl(8'h14, 8'h00); pl(8'h15, 8'h00);
      pl(8'h7F, 8'h99);
      pl(8'hFD, 8'hAA); pl(8'hFE, 8'h11); pl(8'hFF, 8'h22);
      pl(8'h00, 8'h33); pl(8'h01, 8'h44); pl(8'h02, 8'h55);
      pl(8'hA0, 8'h55); pl(8'hA1, 8'h55); pl(8'hA2, 8'h55); pl(8'hA3, 8'h55);

      chk("rst_acks", {62'h0, if_ack, dm_ack}, 64'h0);
      chk("rst_inst", {16'h0, if_inst}, 64'h0);
      chk("rst_rdata", {32'h0, dm_rdata}, 64'h0);
      chk("rst_ram", {23'h0, ram_we, ram_wdata, ram_addr}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      rst = 1'b0;
      step();

      vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          48'h30F0_0400_0000, 8};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF,  48'h0,              5};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          48'hDEAD_BEEF,      6};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0102_0304,  48'hDEAD_BEEF,      5};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_007F, 32'h0,          48'h0203_0499,      6};
      vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0,          48'h4433_2211,      6};
      vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0,          48'hAA11_2233_4455, 8};

      for (int i = 0; i < 7; i++) begin
         do_txn(vecs[i].fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                lat, data, we_cnt, addr_ok, other, pulse_ok);
         chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("v%0d_data", i), {16'h0, data}, {16'h0, vecs[i].exp_data});
         chk($sformatf("v%0d_we_cnt", i), 64'(we_cnt), vecs[i].we ? 64'd4 : 64'd0);
         chk($sformatf("v%0d_addr_seq", i), {63'h0, addr_ok}, 64'h1);
         chk($sformatf("v%0d_other_ack", i), {63'h0, other}, 64'h0);
         chk($sformatf("v%0d_pulse", i), {63'h0, pulse_ok}, 64'h1);
      end
      chk("mem_40", {32'h0, mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 64'hDEAD_BEEF);
      chk("mem_80", {32'h0, mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 64'h0102_0304);

      // Both requesters held high across several grants.
      wait_idle();
      dm_we = 1'b0; dm_addr = 32'h40; if_addr = 32'h10;
      dm_req = 1'b1; if_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dm_req = 1'b0;
         g = 0;
         while (!(if_ack || dm_ack) && g < 30) begin step(); g++; end
         order[i] = (if_ack && dm_ack) ? 3 : dm_ack ? 1 : if_ack ? 0 : 2;
         if (dm_ack) chk($sformatf("tie%0d_rdata", i), {32'h0, dm_rdata}, 64'hDEAD_BEEF);
         if (if_ack) chk($sformatf("tie%0d_inst", i), {16'h0, if_inst}, 64'h30F0_0400_0000);
         step();
      end
      if_req = 1'b0;
`ifdef MEM_ARB_RR_EN
      exp_order = '{1, 0, 1};
`else
      exp_order = '{1, 1, 1};
`endif
      for (int i = 0; i < 3; i++)
         chk($sformatf("tie_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
      chk("tie_fetch_after_drop", 64'(order[3]), 64'd0);

      // Fetch address changed after grant must not affect the result.
      wait_idle();
      if_addr = 32'h10; if_req = 1'b1;
      lat = 0;
      while (!if_ack && lat < 30) begin
         step(); lat++;
         if (lat == 2) if_addr = 32'h40;
      end
      chk("hold_lat", 64'(lat), 64'd8);
      chk("hold_inst", {16'h0, if_inst}, 64'h30F0_0400_0000);
      if_req = 1'b0;
      step();

      // Reset after two write beats: bytes 0-1 land, 2-3 stay untouched.
      wait_idle();
      dm_addr = 32'hA0; dm_we = 1'b1; dm_wdata = 32'h4433_2211; dm_req = 1'b1;
      step(); step();
      chk("rstw_we_before", {63'h0, ram_we}, 64'h1);
      rst = 1'b1; dm_req = 1'b0;
      step();
      chk("rstw_busy", {63'h0, busy}, 64'h0);
      chk("rstw_we", {63'h0, ram_we}, 64'h0);
      chk("rstw_ack", {63'h0, dm_ack}, 64'h0);
      rst = 1'b0;
      g = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (dm_ack || if_ack || busy) g++;
      end
      chk("rstw_quiet", 64'(g), 64'd0);
      chk("rstw_mem", {32'h0, mem[8'hA3], mem[8'hA2], mem[8'hA1], mem[8'hA0]}, 64'h5555_2211);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
